// File: rtl/reglist_sequencer_if.sv
// Bundles the control request, register-file ports and memory bus of the
// block-transfer sequencer; master is the sequencer, slave is its environment.
interface reglist_sequencer_if #(
  parameter int unsigned NREGS = 16
);
  localparam int unsigned IDX_W = $clog2(NREGS);

  logic              start;
  logic              is_load;
  logic              up;
  logic              pre;
  logic              writeback;
  logic [IDX_W-1:0]  rn;
  logic [31:0]       base;
  logic [NREGS-1:0]  reglist;

  logic [IDX_W-1:0]  rf_a1;
  logic [31:0]       rf_rd1;
  logic [IDX_W-1:0]  rf_a3;
  logic [31:0]       rf_wd3;
  logic              rf_we3;

  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  logic              busy;
  logic              done;

  modport master (
    input  start, is_load, up, pre, writeback, rn, base, reglist,
    input  rf_rd1, mem_rdata, mem_ready,
    output rf_a1, rf_a3, rf_wd3, rf_we3,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output busy, done
  );

  modport slave (
    output start, is_load, up, pre, writeback, rn, base, reglist,
    output rf_rd1, mem_rdata, mem_ready,
    input  rf_a1, rf_a3, rf_wd3, rf_we3,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  busy, done
  );
endinterface

// File: rtl/reglist_sequencer.sv
// LDM/STM-style sequencer: walks a register list in ascending order, moving
// each register to/from memory, then optionally writes the final address back.
module reglist_sequencer #(
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned NREGS      = 16
) (
  input  logic                clk,
  input  logic                reset,
  reglist_sequencer_if.master bus
);
  localparam int unsigned IDX_W = $clog2(NREGS);
  localparam int unsigned CNT_W = $clog2(NREGS + 1);
  localparam int unsigned AW    = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_RDREG, S_STORE, S_LOAD, S_WRREG, S_WB, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [NREGS-1:0]  pending_q, pending_d;
  logic [NREGS-1:0]  list_q, list_d;
  logic              is_load_q, is_load_d;
  logic              wb_q, wb_d;
  logic [IDX_W-1:0]  rn_q, rn_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [AW-1:0]     final_q, final_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              rd_phase_q, rd_phase_d;

  logic [IDX_W-1:0]  rf_a1_q, rf_a1_d;
  logic [IDX_W-1:0]  rf_a3_q, rf_a3_d;
  logic [AW-1:0]     rf_wd3_q, rf_wd3_d;
  logic              rf_we3_q, rf_we3_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [AW-1:0]     mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [IDX_W-1:0]  low_idx;
  logic [CNT_W-1:0]  list_cnt;
  logic [AW-1:0]     stride, span, start_addr, final_addr;
  logic              wb_write;

  // Lowest pending register index
  always_comb begin : find_low
    low_idx = '0;
    for (int i = int'(NREGS) - 1; i >= 0; i--) begin
      if (pending_q[i]) low_idx = IDX_W'(i);
    end
  end

  // Address window derived from the incoming request
  always_comb begin : addr_window
    list_cnt = '0;
    for (int i = 0; i < int'(NREGS); i++) begin
      list_cnt = list_cnt + CNT_W'(bus.reglist[i]);
    end
    stride = AW'(WORD_BYTES);
    span   = AW'(list_cnt) * stride;
    case ({bus.up, bus.pre})
      2'b10:   start_addr = bus.base;
      2'b11:   start_addr = bus.base + stride;
      2'b00:   start_addr = bus.base - span + stride;
      default: start_addr = bus.base - span;
    endcase
    final_addr = bus.up ? (bus.base + span) : (bus.base - span);
  end

  // A load that includes the base register keeps the loaded value
  assign wb_write = wb_q && (list_q != '0) && !(is_load_q && list_q[rn_q]);

  always_comb begin : next_state
    state_d     = state_q;
    pending_d   = pending_q;
    list_d      = list_q;
    is_load_d   = is_load_q;
    wb_d        = wb_q;
    rn_d        = rn_q;
    addr_d      = addr_q;
    final_d     = final_q;
    idx_d       = idx_q;
    rd_phase_d  = rd_phase_q;
    rf_a1_d     = '0;
    rf_a3_d     = '0;
    rf_wd3_d    = '0;
    rf_we3_d    = 1'b0;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          pending_d = bus.reglist;
          list_d    = bus.reglist;
          is_load_d = bus.is_load;
          wb_d      = bus.writeback;
          rn_d      = bus.rn;
          addr_d    = start_addr;
          final_d   = final_addr;
          state_d   = S_SCAN;
        end
      end
      S_SCAN: begin
        if (pending_q == '0) begin
          state_d = S_WB;
          if (wb_write) begin
            rf_we3_d = 1'b1;
            rf_a3_d  = rn_q;
            rf_wd3_d = final_q;
          end
        end else begin
          idx_d = low_idx;
          if (is_load_q) begin
            state_d    = S_LOAD;
            mem_req_d  = 1'b1;
            mem_addr_d = addr_q;
          end else begin
            state_d    = S_RDREG;
            rf_a1_d    = low_idx;
            rd_phase_d = 1'b0;
          end
        end
      end
      // First cycle presents rf_a1; second cycle captures the read data
      S_RDREG: begin
        if (!rd_phase_q) begin
          rd_phase_d = 1'b1;
        end else begin
          state_d     = S_STORE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = bus.rf_rd1;
        end
      end
      S_STORE: begin
        if (bus.mem_ready) begin
          pending_d[idx_q] = 1'b0;
          addr_d           = addr_q + stride;
          state_d          = S_SCAN;
        end else begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = mem_addr_q;
          mem_wdata_d = mem_wdata_q;
        end
      end
      S_LOAD: begin
        if (bus.mem_ready) begin
          pending_d[idx_q] = 1'b0;
          addr_d           = addr_q + stride;
          rf_we3_d         = 1'b1;
          rf_a3_d          = idx_q;
          rf_wd3_d         = bus.mem_rdata;
          state_d          = S_WRREG;
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = mem_addr_q;
        end
      end
      S_WRREG: state_d = S_SCAN;
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin : regs
    if (reset) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      list_q      <= '0;
      is_load_q   <= 1'b0;
      wb_q        <= 1'b0;
      rn_q        <= '0;
      addr_q      <= '0;
      final_q     <= '0;
      idx_q       <= '0;
      rd_phase_q  <= 1'b0;
      rf_a1_q     <= '0;
      rf_a3_q     <= '0;
      rf_wd3_q    <= '0;
      rf_we3_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      list_q      <= list_d;
      is_load_q   <= is_load_d;
      wb_q        <= wb_d;
      rn_q        <= rn_d;
      addr_q      <= addr_d;
      final_q     <= final_d;
      idx_q       <= idx_d;
      rd_phase_q  <= rd_phase_d;
      rf_a1_q     <= rf_a1_d;
      rf_a3_q     <= rf_a3_d;
      rf_wd3_q    <= rf_wd3_d;
      rf_we3_q    <= rf_we3_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.rf_a1     = rf_a1_q;
  assign bus.rf_a3     = rf_a3_q;
  assign bus.rf_wd3    = rf_wd3_q;
  assign bus.rf_we3    = rf_we3_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule
